// File: rtl/sub_serial.sv
// Bit-serial LSB-first subtractor: q = a - b - bin, one bit per clock through one full-subtractor cell.
// Optional status flags (zero/negative/signed overflow) are built only when SUB_SERIAL_FLAGS_EN is defined.
module sub_serial #(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             bout,
  output logic             zf,
  output logic             nf,
  output logic             vf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;

  logic             accept;
  logic             last_bit;
  logic             diff_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] work_nxt;

  // Single full-subtractor cell operating on the current LSBs.
  always_comb begin
    diff_bit = sa_q[0] ^ sb_q[0] ^ br_q;
    br_nxt   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    work_nxt = {diff_bit, work_q[WIDTH-1:1]};
    last_bit = (cnt_q == CW'(WIDTH - 1));
    accept   = start && (state_q != S_RUN);
  end

`ifdef SUB_SERIAL_FLAGS_EN
  logic a_sign_q, a_sign_d;
  logic b_sign_q, b_sign_d;
  logic zf_q, zf_d;
  logic nf_q, nf_d;
  logic vf_q, vf_d;
`endif

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    work_d  = work_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SUB_SERIAL_FLAGS_EN
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    zf_d     = zf_q;
    nf_d     = nf_q;
    vf_d     = vf_q;
`endif

    if (accept) begin
      // Accept from IDLE or straight out of DONE for back-to-back operation.
      state_d = S_RUN;
      sa_d    = a;
      sb_d    = b;
      br_d    = bin;
      cnt_d   = '0;
      work_d  = '0;
`ifdef SUB_SERIAL_FLAGS_EN
      a_sign_d = a[WIDTH-1];
      b_sign_d = b[WIDTH-1];
`endif
    end else if (state_q == S_RUN) begin
      sa_d   = sa_q >> 1;
      sb_d   = sb_q >> 1;
      br_d   = br_nxt;
      work_d = work_nxt;
      cnt_d  = cnt_q + CW'(1);
      if (last_bit) begin
        state_d = S_DONE;
        q_d     = work_nxt;
        bout_d  = br_nxt;
`ifdef SUB_SERIAL_FLAGS_EN
        zf_d = (work_nxt == '0);
        nf_d = work_nxt[WIDTH-1];
        vf_d = (a_sign_q ^ b_sign_q) & (a_sign_q ^ work_nxt[WIDTH-1]);
`endif
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      work_q  <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      work_q  <= work_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SUB_SERIAL_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      vf_q     <= 1'b0;
    end else begin
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      zf_q     <= zf_d;
      nf_q     <= nf_d;
      vf_q     <= vf_d;
    end
  end

  assign zf = zf_q;
  assign nf = nf_q;
  assign vf = vf_q;
`else
  assign zf = 1'b0;
  assign nf = 1'b0;
  assign vf = 1'b0;
`endif

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign q    = q_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial (WIDTH=15); flag expectations follow SUB_SERIAL_FLAGS_EN.
module tb_sub_serial;

`ifdef SUB_SERIAL_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [14:0] a = '0;
  logic [14:0] b = '0;
  logic        bin = 1'b0;
  logic        busy, done, bout, zf, nf, vf;
  logic [14:0] q;

  int vectors = 0;
  int miscompares = 0;

  sub_serial #(.WIDTH(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .q(q), .bout(bout), .zf(zf), .nf(nf), .vf(vf)
  );

  always #5 clk = ~clk;

  // Drive one start pulse; returns at the negedge one cycle after acceptance.
  task automatic start_op(input logic [14:0] ta, input logic [14:0] tb, input logic tbin);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; cyc counts cycles from the cycle start was driven.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, q, bout, zf, nf, vf} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h want=0", {busy, done, q, bout, zf, nf, vf});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int cyc;
    start_op(15'h0005, 15'h0003, 1'b0);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    wait_done(cyc);
    vectors++;
    if (cyc !== 16) begin
      miscompares++;
      $display("FAIL basic_latency got=%0d want=16", cyc);
    end
    vectors++;
    if (q !== 15'h0002 || bout !== 1'b0 || {zf, nf, vf} !== 3'b000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result got q=%h bout=%b zf/nf/vf=%b%b%b busy=%b want q=0002 bout=0 000 busy=0",
               q, bout, zf, nf, vf, busy);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || q !== 15'h0002) begin
      miscompares++;
      $display("FAIL basic_pulse got done=%b q=%h want done=0 q=0002", done, q);
    end
  endtask

  task automatic test_borrow;
    int cyc;
    start_op(15'h0000, 15'h0001, 1'b0);
    wait_done(cyc);
    vectors++;
    if (q !== 15'h7FFF || bout !== 1'b1 || zf !== 1'b0 || nf !== FL || vf !== 1'b0) begin
      miscompares++;
      $display("FAIL borrow_neg got q=%h bout=%b zf=%b nf=%b vf=%b want q=7fff bout=1 zf=0 nf=%b vf=0",
               q, bout, zf, nf, vf, FL);
    end
    @(negedge clk);
    start_op(15'h0005, 15'h0003, 1'b1);
    wait_done(cyc);
    vectors++;
    if (q !== 15'h0001 || bout !== 1'b0 || cyc !== 16) begin
      miscompares++;
      $display("FAIL borrow_in got q=%h bout=%b lat=%0d want q=0001 bout=0 lat=16", q, bout, cyc);
    end
  endtask

  task automatic test_overflow;
    int cyc;
    @(negedge clk);
    start_op(15'h3FFF, 15'h7FFF, 1'b0);
    wait_done(cyc);
    vectors++;
    if (q !== 15'h4000 || bout !== 1'b1 || zf !== 1'b0 || nf !== FL || vf !== FL) begin
      miscompares++;
      $display("FAIL overflow got q=%h bout=%b zf=%b nf=%b vf=%b want q=4000 bout=1 zf=0 nf=%b vf=%b",
               q, bout, zf, nf, vf, FL, FL);
    end
  endtask

  task automatic test_zero_ignore;
    int dones = 0;
    logic [14:0] q_at_done = 15'h7AAA;
    logic        zf_at_done = 1'b0;
    @(negedge clk);
    start_op(15'h1234, 15'h1234, 1'b0);
    repeat (4) @(negedge clk);
    // Mid-RUN start with different operands must be dropped.
    start_op(15'h7000, 15'h0001, 1'b0);
    for (int i = 0; i < 35; i++) begin
      if (done) begin
        dones++;
        q_at_done = q;
        zf_at_done = zf;
      end
      @(negedge clk);
    end
    vectors++;
    if (dones !== 1) begin
      miscompares++;
      $display("FAIL ignore_done_count got=%0d want=1", dones);
    end
    vectors++;
    if (q_at_done !== 15'h0000 || zf_at_done !== FL || q !== 15'h0000 || bout !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_result got q=%h zf=%b q_now=%h bout=%b want q=0000 zf=%b bout=0",
               q_at_done, zf_at_done, q, bout, FL);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    start_op(15'h0005, 15'h0003, 1'b0);
    wait_done(cyc);
    vectors++;
    if (q !== 15'h0002 || cyc !== 16) begin
      miscompares++;
      $display("FAIL b2b_first got q=%h lat=%0d want q=0002 lat=16", q, cyc);
    end
    // Accept the next operation in the DONE cycle itself.
    start_op(15'h0010, 15'h0001, 1'b0);
    vectors++;
    if (busy !== 1'b1 || q !== 15'h0002) begin
      miscompares++;
      $display("FAIL b2b_accept got busy=%b q=%h want busy=1 q=0002", busy, q);
    end
    wait_done(cyc);
    vectors++;
    if (cyc !== 16 || q !== 15'h000F || bout !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second got lat=%0d q=%h bout=%b want lat=16 q=000f bout=0", cyc, q, bout);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    int dones = 0;
    @(negedge clk);
    start_op(15'h0005, 15'h0003, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, q, bout, zf, nf, vf} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_mid got=%h want=0", {busy, done, q, bout, zf, nf, vf});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL reset_no_done got=%0d active cycles want=0", dones);
    end
    start_op(15'h0005, 15'h0003, 1'b0);
    wait_done(cyc);
    vectors++;
    if (cyc !== 16 || q !== 15'h0002 || bout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_recover got lat=%0d q=%h bout=%b want lat=16 q=0002 bout=0", cyc, q, bout);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_borrow;
    test_overflow;
    test_zero_ignore;
    test_back_to_back;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
